// File: rtl/iotdf_pkg.sv
// iotdf_pkg: shared widths, state encoding and fn_sel codes for the IOTDF byte path
package iotdf_pkg;
   localparam int DATA_W          = 128;
   localparam int BYTES_PER_WORD  = 16;
   localparam int WORDS_PER_ROUND = 8;
   localparam int FN_SEL_W        = 3;
   localparam int BC_W            = $clog2(BYTES_PER_WORD);
   localparam int WC_W            = $clog2(WORDS_PER_ROUND);
   typedef enum logic {IDLE, SEND} state_t;
   localparam logic [FN_SEL_W-1:0] FN_NONE = 3'd0;
   localparam logic [FN_SEL_W-1:0] FN_MAX  = 3'd1;
   localparam logic [FN_SEL_W-1:0] FN_MIN  = 3'd2;
   localparam logic [FN_SEL_W-1:0] FN_AVG  = 3'd3;
   localparam logic [FN_SEL_W-1:0] FN_EXT  = 3'd4;
   localparam logic [FN_SEL_W-1:0] FN_EXC  = 3'd5;
   localparam logic [FN_SEL_W-1:0] FN_PMAX = 3'd6;
   localparam logic [FN_SEL_W-1:0] FN_PMIN = 3'd7;
endpackage

// File: rtl/iotdf_byte_feeder_if.sv
// iotdf_byte_feeder_if: upstream word handshake plus IOTDF byte-stream signals
interface iotdf_byte_feeder_if;
   import iotdf_pkg::*;
   logic                blk_valid;
   logic [DATA_W-1:0]   blk_data;
   logic                blk_ready;
   logic [FN_SEL_W-1:0] fn_sel_in;
   logic                busy;
   logic                in_en;
   logic [7:0]          iot_in;
   logic [FN_SEL_W-1:0] fn_sel;
   logic                round_done;
   modport master (input blk_valid, blk_data, fn_sel_in, busy,
                   output blk_ready, in_en, iot_in, fn_sel, round_done);
   modport slave  (output blk_valid, blk_data, fn_sel_in, busy,
                   input blk_ready, in_en, iot_in, fn_sel, round_done);
endinterface

// File: rtl/iotdf_frame_cnt.sv
// iotdf_frame_cnt: byte-in-word and word-in-round counters with end-of-word/round flags
module iotdf_frame_cnt
   import iotdf_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            adv,
   output logic [BC_W-1:0] byte_cnt,
   output logic [WC_W-1:0] word_cnt,
   output logic            last_byte,
   output logic            wrap
);
   logic last_word;
   // flags decoded from the current counts; wrap marks the final byte transfer of a round
   always_comb begin
      last_byte = byte_cnt == BC_W'(BYTES_PER_WORD - 1);
      last_word = word_cnt == WC_W'(WORDS_PER_ROUND - 1);
      wrap      = adv && last_byte && last_word;
   end
   // advance per transferred byte; the word count steps on each word's last byte
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt <= '0;
         word_cnt <= '0;
      end else if (adv) begin
         byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
         word_cnt <= !last_byte ? word_cnt : last_word ? '0 : word_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/iotdf_byte_feeder.sv
// iotdf_byte_feeder: serialises 128-bit words MSB-byte-first into IOTDF, framed in rounds
module iotdf_byte_feeder
   import iotdf_pkg::*;
(
   input  logic clk,
   input  logic rst,
   iotdf_byte_feeder_if.master bus
);
   state_t              state, state_nxt;
   logic [DATA_W-1:0]   shreg;
   logic [FN_SEL_W-1:0] fn_sel_q;
   logic                round_done_q;
   logic [BC_W-1:0]     byte_cnt;
   logic [WC_W-1:0]     word_cnt;
   logic                last_byte, wrap, xfer, last_xfer, load, round_start;
   iotdf_frame_cnt u_cnt (
      .clk       (clk),
      .rst       (rst),
      .adv       (xfer),
      .byte_cnt  (byte_cnt),
      .word_cnt  (word_cnt),
      .last_byte (last_byte),
      .wrap      (wrap)
   );
   // handshake, byte strobe and next state; ready also opens on the last byte for zero-bubble reload
   always_comb begin
      xfer           = !rst && state == SEND && !bus.busy;
      last_xfer      = xfer && last_byte;
      bus.blk_ready  = !rst && (state == IDLE || last_xfer);
      load           = bus.blk_valid && bus.blk_ready;
      round_start    = (state == IDLE && word_cnt == '0) || wrap;
      state_nxt      = load ? SEND : last_xfer ? IDLE : state;
      bus.in_en      = xfer;
      bus.iot_in     = (!rst && state == SEND) ? shreg[DATA_W-1 -: 8] : 8'h00;
      bus.fn_sel     = rst ? '0 : fn_sel_q;
      bus.round_done = !rst && round_done_q;
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   // shift register, round-frozen fn_sel and registered round_done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg        <= '0;
         fn_sel_q     <= '0;
         round_done_q <= 1'b0;
      end else begin
         shreg        <= load ? bus.blk_data : xfer ? shreg << 8 : shreg;
         fn_sel_q     <= (load && round_start) ? bus.fn_sel_in : fn_sel_q;
         round_done_q <= wrap;
      end
   end
endmodule

// File: tb/tb_iotdf_byte_feeder.sv
// tb_iotdf_byte_feeder: directed checks of serialisation, back-pressure, rounds and reset
module tb_iotdf_byte_feeder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   iotdf_byte_feeder_if bus ();
   iotdf_byte_feeder dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic logic [127:0] word(input int w);
      logic [127:0] d;
      for (int k = 0; k < 16; k++) d[127-8*k -: 8] = {w[3:0], k[3:0]};
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      bus.blk_valid = 1'b0;
      bus.busy = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_in_en", bus.in_en, 0);
      chk("rst_iot_in", bus.iot_in, 0);
      chk("rst_ready", bus.blk_ready, 0);
      chk("rst_fn_sel", bus.fn_sel, 0);
      chk("rst_rdone", bus.round_done, 0);
      rst = 1'b0;
   endtask

   task automatic stream(input int nb, input logic [2:0] f, input int chg, input bit stop);
      int w, k;
      for (int b = 0; b < nb; b++) begin
         @(negedge clk);
         #1;
         w = b / 16;
         k = b % 16;
         chk("s_in_en", bus.in_en, 1);
         chk("s_iot_in", bus.iot_in, {24'h0, w[3:0], k[3:0]});
         chk("s_fn_sel", bus.fn_sel, f);
         chk("s_rdone", bus.round_done, 0);
         chk("s_ready", bus.blk_ready, k == 15);
         if (b == chg) bus.fn_sel_in = 3'd6;
         if (k == 15) begin
            bus.blk_data = word(w + 1);
            if (stop && b == nb - 1) bus.blk_valid = 1'b0;
         end
      end
   endtask

   initial begin
      bus.blk_valid = 1'b0;
      bus.blk_data  = '0;
      bus.fn_sel_in = 3'd0;
      bus.busy      = 1'b0;
      // single word, 1-cycle load latency, return to IDLE
      do_reset();
      @(negedge clk);
      bus.fn_sel_in = 3'd1;
      bus.blk_valid = 1'b1;
      bus.blk_data  = 128'h000102030405060708090A0B0C0D0E0F;
      #1;
      chk("t1_ready_idle", bus.blk_ready, 1);
      chk("t1_in_en_idle", bus.in_en, 0);
      stream(16, 3'd1, -1, 1);
      @(negedge clk);
      #1;
      chk("t1_in_en_end", bus.in_en, 0);
      chk("t1_ready_end", bus.blk_ready, 1);
      chk("t1_iot_end", bus.iot_in, 0);
      chk("t1_rdone", bus.round_done, 0);
      // full round back-to-back, fn_sel_in change mid-round ignored, next round latches 6
      do_reset();
      @(negedge clk);
      bus.fn_sel_in = 3'd4;
      bus.blk_valid = 1'b1;
      bus.blk_data  = word(0);
      #1;
      chk("t2_ready", bus.blk_ready, 1);
      stream(128, 3'd4, 48, 1);
      @(negedge clk);
      #1;
      chk("t2_rdone", bus.round_done, 1);
      chk("t2_in_en_end", bus.in_en, 0);
      chk("t2_fn_sel_end", bus.fn_sel, 4);
      chk("t2_ready_end", bus.blk_ready, 1);
      bus.blk_valid = 1'b1;
      bus.blk_data  = word(0);
      @(negedge clk);
      #1;
      chk("t4_rdone_drop", bus.round_done, 0);
      chk("t4_fn_sel_new", bus.fn_sel, 6);
      chk("t4_in_en", bus.in_en, 1);
      chk("t4_iot_in", bus.iot_in, 8'h00);
      bus.blk_valid = 1'b0;
      // busy for 5 cycles at byte 7
      do_reset();
      @(negedge clk);
      bus.fn_sel_in = 3'd1;
      bus.blk_valid = 1'b1;
      bus.blk_data  = word(0);
      stream(7, 3'd1, -1, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.busy = 1'b1;
         #1;
         chk("t3_busy_in_en", bus.in_en, 0);
         chk("t3_busy_iot", bus.iot_in, 8'h07);
         chk("t3_busy_ready", bus.blk_ready, 0);
      end
      for (int k = 7; k < 16; k++) begin
         @(negedge clk);
         bus.busy = 1'b0;
         #1;
         chk("t3_in_en", bus.in_en, 1);
         chk("t3_iot_in", bus.iot_in, k);
         chk("t3_ready", bus.blk_ready, k == 15);
         if (k == 15) bus.blk_valid = 1'b0;
      end
      @(negedge clk);
      #1;
      chk("t3_in_en_end", bus.in_en, 0);
      chk("t3_ready_end", bus.blk_ready, 1);
      // reset at byte 9 of word 2, then a fresh full round
      do_reset();
      @(negedge clk);
      bus.fn_sel_in = 3'd2;
      bus.blk_valid = 1'b1;
      bus.blk_data  = word(0);
      stream(41, 3'd2, -1, 0);
      @(negedge clk);
      rst = 1'b1;
      bus.blk_data  = word(0);
      bus.fn_sel_in = 3'd5;
      #1;
      chk("t5_rst_in_en", bus.in_en, 0);
      chk("t5_rst_ready", bus.blk_ready, 0);
      chk("t5_rst_iot", bus.iot_in, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_post_in_en", bus.in_en, 0);
      chk("t5_post_ready", bus.blk_ready, 1);
      chk("t5_post_fn_sel", bus.fn_sel, 0);
      stream(128, 3'd5, -1, 1);
      @(negedge clk);
      #1;
      chk("t5_rdone", bus.round_done, 1);
      chk("t5_fn_sel", bus.fn_sel, 5);
      // busy on the last byte with a word waiting
      do_reset();
      @(negedge clk);
      bus.fn_sel_in = 3'd3;
      bus.blk_valid = 1'b1;
      bus.blk_data  = word(0);
      stream(15, 3'd3, -1, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.busy = 1'b1;
         bus.blk_data = word(5);
         #1;
         chk("t6_busy_in_en", bus.in_en, 0);
         chk("t6_busy_ready", bus.blk_ready, 0);
         chk("t6_busy_iot", bus.iot_in, 8'h0F);
      end
      @(negedge clk);
      bus.busy = 1'b0;
      #1;
      chk("t6_last_in_en", bus.in_en, 1);
      chk("t6_last_iot", bus.iot_in, 8'h0F);
      chk("t6_last_ready", bus.blk_ready, 1);
      @(negedge clk);
      bus.blk_valid = 1'b0;
      #1;
      chk("t6_new_in_en", bus.in_en, 1);
      chk("t6_new_iot", bus.iot_in, 8'h50);
      chk("t6_new_ready", bus.blk_ready, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
